vga_timing_gen: RTL

Source end of the `vga_if` pixel stream: generates the 1024x768@60 raster (`hcount`/`vcount`, sync and blanking) that every downstream draw stage consumes. It sits at the head of the video pipeline, ahead of the background and sprite draw stages. It adds a frame-aligned run/stop control so the display can be gated without tearing. All outputs are registered.

---
 rtl/vga_timing_gen_if.sv | 19 +
 rtl/vga_timing_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_if                                                               |
// | Raster pixel-stream bundle passed between video pipeline stages.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing_gen                                                       |
// | 1024x768@60 raster source with frame-aligned run/stop control.       |
// | Optional completed-frame counter: define VGA_TIMING_FRAME_CNT_EN.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module vga_timing_gen #(
    parameter int HOR_PIXELS = 1024,
    parameter int HOR_FP     = 24,
    parameter int HOR_SYNC   = 136,
    parameter int HOR_BP     = 160,
    parameter int VER_PIXELS = 768,
    parameter int VER_FP     = 3,
    parameter int VER_SYNC   = 6,
    parameter int VER_BP     = 29
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    vga_if.out          vga_out,
    output logic        frame_start,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam logic [10:0] c_H_ACT    = 11'(HOR_PIXELS);
    localparam logic [10:0] c_H_SYNC_S = 11'(HOR_PIXELS + HOR_FP);
    localparam logic [10:0] c_H_SYNC_E = 11'(HOR_PIXELS + HOR_FP + HOR_SYNC - 1);
    localparam logic [10:0] c_H_LAST   = 11'(HOR_PIXELS + HOR_FP + HOR_SYNC + HOR_BP - 1);
    localparam logic [10:0] c_V_ACT    = 11'(VER_PIXELS);
    localparam logic [10:0] c_V_SYNC_S = 11'(VER_PIXELS + VER_FP);
    localparam logic [10:0] c_V_SYNC_E = 11'(VER_PIXELS + VER_FP + VER_SYNC - 1);
    localparam logic [10:0] c_V_LAST   = 11'(VER_PIXELS + VER_FP + VER_SYNC + VER_BP - 1);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_RUN      = 2'd1;
    localparam logic [1:0] c_ST_STOPPING = 2'd2;

    logic [1:0]  r_state;
    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_hblnk;
    logic        r_vblnk;
    logic        r_frame_start;
    logic        r_busy;

    logic [1:0]  w_state_next;
    logic [10:0] w_h_next;
    logic [10:0] w_v_next;
    logic        w_active_next;
    logic        w_line_end;
    logic        w_frame_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_h_next     = 11'd0;
        w_v_next     = 11'd0;
        w_line_end   = (r_hcount == c_H_LAST);
        w_frame_end  = w_line_end && (r_vcount == c_V_LAST);

        case (r_state)
            c_ST_IDLE: begin
                if (en) w_state_next = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (!en) w_state_next = c_ST_STOPPING;
            end
            c_ST_STOPPING: begin
                // A stop only takes effect once the last pixel of the frame is out.
                if (en)               w_state_next = c_ST_RUN;
                else if (w_frame_end) w_state_next = c_ST_IDLE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase

        w_active_next = (w_state_next != c_ST_IDLE);

        // Leaving IDLE starts at (0,0); the default zeros already cover that.
        if (w_active_next && (r_state != c_ST_IDLE)) begin
            if (w_line_end) begin
                w_h_next = 11'd0;
                w_v_next = w_frame_end ? 11'd0 : r_vcount + 11'd1;
            end else begin
                w_h_next = r_hcount + 11'd1;
                w_v_next = r_vcount;
            end
        end
    end

    // Decode is taken from the next-count value so it lines up with the count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcount      <= 11'd0;
            r_vcount      <= 11'd0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_hblnk       <= 1'b1;
            r_vblnk       <= 1'b1;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_hcount      <= w_h_next;
            r_vcount      <= w_v_next;
            r_hsync       <= w_active_next && (w_h_next >= c_H_SYNC_S) && (w_h_next <= c_H_SYNC_E);
            r_vsync       <= w_active_next && (w_v_next >= c_V_SYNC_S) && (w_v_next <= c_V_SYNC_E);
            r_hblnk       <= !w_active_next || (w_h_next >= c_H_ACT);
            r_vblnk       <= !w_active_next || (w_v_next >= c_V_ACT);
            r_frame_start <= w_active_next && (w_h_next == 11'd0) && (w_v_next == 11'd0);
            r_busy        <= w_active_next;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 16'd0;
        end else if ((r_state != c_ST_IDLE) && w_frame_end) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = 16'd0;
`endif

    assign vga_out.hcount = r_hcount;
    assign vga_out.vcount = r_vcount;
    assign vga_out.hsync  = r_hsync;
    assign vga_out.vsync  = r_vsync;
    assign vga_out.hblnk  = r_hblnk;
    assign vga_out.vblnk  = r_vblnk;
    assign vga_out.rgb    = 12'h000;
    assign frame_start    = r_frame_start;
    assign busy           = r_busy;

endmodule
`default_nettype wire
